// File: rtl/spi_bus_pkg.sv
// Shared types and elaboration helpers for the SPI-to-register-bus bridge.
package spi_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_WDATA,
        ST_RDATA
    } state_e;

    // Header is {wr, addr}: one flag bit above the address field.
    function automatic int hdr_width(input int addr_w);
        return addr_w + 1;
    endfunction

    // Bit position of the write flag inside the header word.
    function automatic int wr_flag_idx(input int addr_w);
        return addr_w;
    endfunction

    // MOSI is sampled on the rising SCLK edge when CPOL and CPHA agree.
    function automatic bit sample_on_rise(input bit cpol, input bit cpha);
        return (cpol ^ cpha) == 1'b0;
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Brings the asynchronous SPI pins into the i_clk domain and turns SCLK/SSEL
// transitions into single-cycle pulses that are all aligned to mosi_s_o.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2,
    parameter bit SAMPLE_RISE = 1'b1,
    parameter bit SCLK_IDLE   = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic sclk_i,
    input  logic ssel_i,
    input  logic mosi_i,
    output logic sample_pulse_o,
    output logic shift_pulse_o,
    output logic ssel_fall_o,
    output logic ssel_rise_o,
    output logic ssel_s_o,
    output logic mosi_s_o
);

    logic [SYNC_STAGES-1:0] sclk_sync_q, ssel_sync_q, mosi_sync_q;
    logic sclk_prev_q, ssel_prev_q;
    logic sample_q, shift_q, fall_q, rise_q, mosi_q;
    logic sclk_s, ssel_s, sclk_rise, sclk_fall;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign ssel_s    = ssel_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;

    // Synchroniser chains, edge detectors and registered edge pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: SSEL restarts low so a reset taken mid-frame cannot fake a
            // select fall; the bridge waits for a genuine high level first.
            sclk_sync_q <= {SYNC_STAGES{SCLK_IDLE}};
            ssel_sync_q <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= SCLK_IDLE;
            ssel_prev_q <= 1'b0;
            sample_q    <= 1'b0;
            shift_q     <= 1'b0;
            fall_q      <= 1'b0;
            rise_q      <= 1'b0;
            mosi_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop sees the pre-edge
            // value of its neighbour; blocking here would collapse the chain.
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            ssel_sync_q <= {ssel_sync_q[SYNC_STAGES-2:0], ssel_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            sclk_prev_q <= sclk_s;
            ssel_prev_q <= ssel_s;
            sample_q    <= SAMPLE_RISE ? sclk_rise : sclk_fall;
            shift_q     <= SAMPLE_RISE ? sclk_fall : sclk_rise;
            fall_q      <= ~ssel_s & ssel_prev_q;
            rise_q      <= ssel_s & ~ssel_prev_q;
            mosi_q      <= mosi_sync_q[SYNC_STAGES-1];
        end
    end

    assign sample_pulse_o = sample_q;
    assign shift_pulse_o  = shift_q;
    assign ssel_fall_o    = fall_q;
    assign ssel_rise_o    = rise_q;
    assign ssel_s_o       = ssel_prev_q;
    assign mosi_s_o       = mosi_q;

endmodule

// File: rtl/spi_bus_bridge.sv
// SPI slave to register-bus bridge: header {wr, addr}, then data words with
// optional address auto-increment, in any SPI mode.
module spi_bus_bridge
    import spi_bus_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int SYNC_STAGES = 2,
    parameter bit BURST_EN    = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_SCLK,
    input  logic              i_SSEL,
    input  logic              i_MOSI,
    output logic              o_MISO,
    input  logic [DATA_W-1:0] i_data_read_bus,
    output logic [ADDR_W-1:0] o_addr_bus,
    output logic [DATA_W-1:0] o_data_write_bus,
    output logic              o_wr_enable_bus,
    output logic              o_rd_enable_bus,
    output logic              o_busy,
    output logic              o_frame_err
);

    localparam int HDR_W  = hdr_width(ADDR_W);
    localparam int WR_IDX = wr_flag_idx(ADDR_W);
    localparam int SH_W   = (HDR_W > DATA_W) ? HDR_W : DATA_W;
    localparam int CNT_W  = $clog2(SH_W + 1);
    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    logic sample_pulse, shift_pulse, ssel_fall, ssel_rise, ssel_s, mosi_s;

    spi_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .SAMPLE_RISE (sample_on_rise(CPOL, CPHA)),
        .SCLK_IDLE   (CPOL)
    ) u_pin_sync (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .sclk_i         (i_SCLK),
        .ssel_i         (i_SSEL),
        .mosi_i         (i_MOSI),
        .sample_pulse_o (sample_pulse),
        .shift_pulse_o  (shift_pulse),
        .ssel_fall_o    (ssel_fall),
        .ssel_rise_o    (ssel_rise),
        .ssel_s_o       (ssel_s),
        .mosi_s_o       (mosi_s)
    );

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SH_W-2:0]   rx_q, rx_d;
    logic [SH_W-1:0]   rx_next;
    logic [DATA_W-1:0] tx_q, tx_d, wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic wr_en_q, wr_en_d, rd_en_q, rd_en_d, cap_q, cap_d, inc_q, inc_d;
    logic done_q, done_d, armed_q, armed_d, err_q, err_d, miso_q, miso_d;

    assign rx_next = {rx_q, mosi_s};

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rx_q    <= '0;
            tx_q    <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            cap_q   <= 1'b0;
            inc_q   <= 1'b0;
            done_q  <= 1'b0;
            armed_q <= 1'b0;
            err_q   <= 1'b0;
            miso_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            wr_en_q <= wr_en_d;
            rd_en_q <= rd_en_d;
            cap_q   <= cap_d;
            inc_q   <= inc_d;
            done_q  <= done_d;
            armed_q <= armed_d;
            err_q   <= err_d;
            miso_q  <= miso_d;
        end
    end

    // Frame decoding, bus strobes and MISO shifting.
    always_comb begin
        // NOTE: every _d gets a default before the case so no path can leave
        // one unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        done_d  = done_q;
        miso_d  = miso_q;
        armed_d = armed_q | ssel_s;
        wr_en_d = 1'b0;
        rd_en_d = 1'b0;
        inc_d   = 1'b0;
        err_d   = 1'b0;
        cap_d   = rd_en_q;   // read data is valid the cycle after the strobe

        // Write bursts advance the address one cycle after the strobe.
        if (inc_q) addr_d = addr_q + ADDR_W'(1);

        unique case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if (ssel_fall && armed_q) begin
                    state_d = ST_HDR;
                    cnt_d   = '0;
                    rx_d    = '0;
                    done_d  = 1'b0;
                end
            end
            ST_HDR: begin
                miso_d = 1'b0;
                if (sample_pulse) begin
                    rx_d = rx_next[SH_W-2:0];
                    if (cnt_q == HDR_LAST) begin
                        cnt_d  = '0;
                        addr_d = rx_next[ADDR_W-1:0];
                        if (rx_next[WR_IDX]) begin
                            state_d = ST_WDATA;
                        end else begin
                            state_d = ST_RDATA;
                            rd_en_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_WDATA: begin
                miso_d = 1'b0;
                if (sample_pulse && !done_q) begin
                    rx_d = rx_next[SH_W-2:0];
                    if (cnt_q == DATA_LAST) begin
                        cnt_d   = '0;
                        wdata_d = rx_next[DATA_W-1:0];
                        wr_en_d = 1'b1;
                        if (BURST_EN) inc_d  = 1'b1;
                        else          done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_RDATA: begin
                if (shift_pulse) begin
                    miso_d = tx_q[DATA_W-1];
                    tx_d   = tx_q << 1;
                end
                if (sample_pulse && !done_q) begin
                    if (cnt_q == DATA_LAST) begin
                        cnt_d = '0;
                        if (BURST_EN) begin
                            addr_d  = addr_q + ADDR_W'(1);
                            rd_en_d = 1'b1;   // prefetch the next word
                        end else begin
                            done_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Fresh read data replaces whatever is left in the TX register.
        if (cap_q) tx_d = i_data_read_bus;

        // Deselect closes any open frame; a partial word is reported.
        if (ssel_rise && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            err_d   = (cnt_q != '0);
        end
    end

    assign o_addr_bus       = addr_q;
    assign o_data_write_bus = wdata_q;
    assign o_wr_enable_bus  = wr_en_q;
    assign o_rd_enable_bus  = rd_en_q;
    assign o_busy           = (state_q != ST_IDLE);
    assign o_frame_err      = err_q;
    assign o_MISO           = (state_q == ST_RDATA) & miso_q;

endmodule

// File: tb/tb_spi_bus_bridge.sv
// Bench for spi_bus_bridge: five instances cover the four SPI modes plus a
// non-burst build; only the selected instance ever sees SSEL low.
module tb_spi_bus_bridge;

    localparam int N    = 5;
    localparam int AW   = 7;
    localparam int DW   = 8;
    localparam int SS   = 2;
    localparam int HALF = 10;   // SCLK half period in i_clk cycles
    // Instance k: bit k of each table. 0:mode0 1:mode1 2:mode2 3:mode3 4:mode0 no burst
    localparam bit [N-1:0] CPOL_T  = 5'b01100;
    localparam bit [N-1:0] CPHA_T  = 5'b01010;
    localparam bit [N-1:0] BURST_T = 5'b01111;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  sclk_v, ssel_v;
    logic          mosi;
    logic          miso_a  [N];
    logic [AW-1:0] addr_a  [N];
    logic [DW-1:0] wdata_a [N];
    logic          wr_a    [N];
    logic          rd_a    [N];
    logic          busy_a  [N];
    logic          err_a   [N];

    int tests = 0, fails = 0;
    int sel = 0;
    int cyc = 0, edge_cyc = 0, err_cnt = 0;
    wr_t           wr_exp_q [$];
    logic [AW-1:0] rd_exp_q [$];
    logic [7:0]    tx_words [8];
    logic [7:0]    rx_words [8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] bus_mem(input logic [AW-1:0] a);
        if (a == 7'h0A) return 8'h15;
        return DW'(a) + 8'h10;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic [DW-1:0] rdata = '0;
        always @(posedge clk) if (rd_a[g]) rdata <= bus_mem(addr_a[g]);

        spi_bus_bridge #(
            .ADDR_W(AW), .DATA_W(DW), .CPOL(CPOL_T[g]), .CPHA(CPHA_T[g]),
            .SYNC_STAGES(SS), .BURST_EN(BURST_T[g])
        ) u_dut (
            .i_clk            (clk),
            .i_rst            (rst),
            .i_SCLK           (sclk_v[g]),
            .i_SSEL           (ssel_v[g]),
            .i_MOSI           (mosi),
            .o_MISO           (miso_a[g]),
            .i_data_read_bus  (rdata),
            .o_addr_bus       (addr_a[g]),
            .o_data_write_bus (wdata_a[g]),
            .o_wr_enable_bus  (wr_a[g]),
            .o_rd_enable_bus  (rd_a[g]),
            .o_busy           (busy_a[g]),
            .o_frame_err      (err_a[g])
        );
    end

    // Scoreboard side: pop an expectation whenever the selected DUT strobes.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_a[sel]) begin
                tests++;
                if (wr_exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL wr_unexpected dut=%0d addr=%h data=%h, no write expected", sel, addr_a[sel], wdata_a[sel]);
                end else begin
                    wr_t e;
                    e = wr_exp_q.pop_front();
                    if (addr_a[sel] !== e.addr || wdata_a[sel] !== e.data) begin
                        fails++;
                        $display("FAIL wr_event dut=%0d got %h/%h expected %h/%h", sel, addr_a[sel], wdata_a[sel], e.addr, e.data);
                    end
                end
                tests++;
                if (cyc - edge_cyc != SS + 2) begin
                    fails++;
                    $display("FAIL wr_latency dut=%0d got %0d cycles expected %0d", sel, cyc - edge_cyc, SS + 2);
                end
                tests++;
                if (rd_a[sel] !== 1'b0) begin
                    fails++;
                    $display("FAIL strobe_overlap dut=%0d rd=%b expected 0", sel, rd_a[sel]);
                end
            end
            if (rd_a[sel]) begin
                tests++;
                if (rd_exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL rd_unexpected dut=%0d addr=%h, no read expected", sel, addr_a[sel]);
                end else begin
                    logic [AW-1:0] ea;
                    ea = rd_exp_q.pop_front();
                    if (addr_a[sel] !== ea) begin
                        fails++;
                        $display("FAIL rd_addr dut=%0d got %h expected %h", sel, addr_a[sel], ea);
                    end
                end
            end
            if (err_a[sel]) err_cnt++;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Master side of nbits, MSB first; MISO is read at each sample edge.
    task automatic xfer_bits(input int nbits, input logic [15:0] val, output logic [15:0] got);
        logic cpol, cpha;
        cpol = CPOL_T[sel];
        cpha = CPHA_T[sel];
        got  = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            if (!cpha) begin
                mosi = val[i];
                wait_clk(HALF);
                got[i] = miso_a[sel];
                edge_cyc = cyc;
                sclk_v[sel] = ~cpol;
                wait_clk(HALF);
                sclk_v[sel] = cpol;
            end else begin
                sclk_v[sel] = ~cpol;
                mosi = val[i];
                wait_clk(HALF);
                got[i] = miso_a[sel];
                edge_cyc = cyc;
                sclk_v[sel] = cpol;
                wait_clk(HALF);
            end
        end
    endtask

    // Full frame: nwords whole words from tx_words, then tail_bits of the next.
    task automatic run_frame(input int nwords, input int tail_bits);
        logic [15:0] got;
        ssel_v[sel] = 1'b0;
        wait_clk(HALF);
        for (int w = 0; w < nwords; w++) begin
            xfer_bits(8, {8'h00, tx_words[w]}, got);
            rx_words[w] = got[7:0];
        end
        if (tail_bits > 0) xfer_bits(tail_bits, {8'h00, tx_words[nwords]}, got);
        wait_clk(HALF);
        ssel_v[sel] = 1'b1;
        wait_clk(2 * HALF);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        sclk_v = CPOL_T;
        ssel_v = '1;
        mosi = 1'b0;
        wait_clk(5);
        for (int k = 0; k < N; k++) begin
            tests++;
            if ({miso_a[k], addr_a[k], wdata_a[k], wr_a[k], rd_a[k], busy_a[k], err_a[k]} !== '0) begin
                fails++;
                $display("FAIL reset_outputs dut=%0d got %b expected all 0", k,
                         {miso_a[k], addr_a[k], wdata_a[k], wr_a[k], rd_a[k], busy_a[k], err_a[k]});
            end
        end
        rst = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic test_write(input int k);
        int e0;
        sel = k;
        e0 = err_cnt;
        wr_exp_q.push_back('{7'h42, 8'h02});
        tx_words[0] = 8'hC2; tx_words[1] = 8'h02;
        run_frame(2, 0);
        tests++;
        if (err_cnt != e0 || wr_exp_q.size() != 0 || rd_exp_q.size() != 0) begin
            fails++;
            $display("FAIL write_frame dut=%0d errs=%0d pending_wr=%0d pending_rd=%0d expected 0 0 0", k, err_cnt - e0, wr_exp_q.size(), rd_exp_q.size());
            wr_exp_q.delete(); rd_exp_q.delete();
        end
    endtask

    task automatic test_read(input int k);
        sel = k;
        rd_exp_q.push_back(7'h0A);
        if (BURST_T[k]) rd_exp_q.push_back(7'h0B);   // prefetch after the word
        tx_words[0] = 8'h0A; tx_words[1] = 8'h00;
        run_frame(2, 0);
        tests++;
        if (rx_words[0] !== 8'h00 || rx_words[1] !== 8'h15) begin
            fails++;
            $display("FAIL read_miso dut=%0d got %h %h expected 00 15", k, rx_words[0], rx_words[1]);
        end
        tests++;
        if (rd_exp_q.size() != 0 || wr_exp_q.size() != 0) begin
            fails++;
            $display("FAIL read_pending dut=%0d rd=%0d wr=%0d expected 0 0", k, rd_exp_q.size(), wr_exp_q.size());
            wr_exp_q.delete(); rd_exp_q.delete();
        end
    endtask

    task automatic test_burst_write;
        sel = 0;
        wr_exp_q.push_back('{7'h70, 8'h04});
        wr_exp_q.push_back('{7'h71, 8'h05});
        wr_exp_q.push_back('{7'h72, 8'h06});
        tx_words[0] = 8'hF0; tx_words[1] = 8'h04; tx_words[2] = 8'h05; tx_words[3] = 8'h06;
        run_frame(4, 0);
        wr_exp_q.push_back('{7'h7F, 8'h0A});
        wr_exp_q.push_back('{7'h00, 8'h0B});
        tx_words[0] = 8'hFF; tx_words[1] = 8'h0A; tx_words[2] = 8'h0B;
        run_frame(3, 0);
        tests++;
        if (wr_exp_q.size() != 0) begin
            fails++;
            $display("FAIL burst_write_pending got %0d expected 0", wr_exp_q.size());
            wr_exp_q.delete();
        end
    endtask

    task automatic test_burst_read;
        sel = 0;
        for (int a = 2; a <= 5; a++) rd_exp_q.push_back(AW'(a));   // 0x05 is the final prefetch
        tx_words[0] = 8'h02; tx_words[1] = 8'h00; tx_words[2] = 8'h00; tx_words[3] = 8'h00;
        run_frame(4, 0);
        tests++;
        if (rx_words[1] !== 8'h12 || rx_words[2] !== 8'h13 || rx_words[3] !== 8'h14) begin
            fails++;
            $display("FAIL burst_read_miso got %h %h %h expected 12 13 14", rx_words[1], rx_words[2], rx_words[3]);
        end
        tests++;
        if (rd_exp_q.size() != 0) begin
            fails++;
            $display("FAIL burst_read_pending got %0d expected 0", rd_exp_q.size());
            rd_exp_q.delete();
        end
    endtask

    task automatic test_abort;
        int e0;
        sel = 0;
        e0 = err_cnt;
        tx_words[0] = 8'hF3; tx_words[1] = 8'h0A;
        run_frame(1, 4);
        tests++;
        if (err_cnt - e0 != 1) begin
            fails++;
            $display("FAIL abort_err_pulse got %0d cycles expected 1", err_cnt - e0);
        end
        test_write(0);
    endtask

    task automatic test_no_burst;
        sel = 4;
        wr_exp_q.push_back('{7'h42, 8'h02});
        tx_words[0] = 8'hC2; tx_words[1] = 8'h02; tx_words[2] = 8'h07;
        run_frame(3, 0);
        tests++;
        if (wr_exp_q.size() != 0) begin
            fails++;
            $display("FAIL no_burst_write_pending got %0d expected 0", wr_exp_q.size());
            wr_exp_q.delete();
        end
        rd_exp_q.push_back(7'h0A);
        tx_words[0] = 8'h0A; tx_words[1] = 8'h00; tx_words[2] = 8'h00;
        run_frame(3, 0);
        tests++;
        if (rx_words[1] !== 8'h15 || rd_exp_q.size() != 0) begin
            fails++;
            $display("FAIL no_burst_read got %h pending=%0d expected 15 pending=0", rx_words[1], rd_exp_q.size());
            rd_exp_q.delete();
        end
    endtask

    task automatic test_reset_midframe;
        logic [15:0] got;
        int e0;
        sel = 0;
        e0 = err_cnt;
        ssel_v[0] = 1'b0;
        wait_clk(HALF);
        xfer_bits(8, 16'h00C2, got);
        xfer_bits(4, 16'h0005, got);
        wait_clk(2);
        tests++;
        if (busy_a[0] !== 1'b1) begin
            fails++;
            $display("FAIL midframe_busy got %b expected 1", busy_a[0]);
        end
        rst = 1'b1;
        wait_clk(2);
        tests++;
        if ({addr_a[0], wdata_a[0], wr_a[0], rd_a[0], busy_a[0], err_a[0], miso_a[0]} !== '0) begin
            fails++;
            $display("FAIL midframe_reset_outputs got %b expected all 0",
                     {addr_a[0], wdata_a[0], wr_a[0], rd_a[0], busy_a[0], err_a[0], miso_a[0]});
        end
        rst = 1'b0;
        wait_clk(1);
        xfer_bits(4, 16'h000A, got);
        xfer_bits(8, 16'h0033, got);
        wait_clk(HALF);
        ssel_v[0] = 1'b1;
        wait_clk(2 * HALF);
        tests++;
        if (err_cnt != e0 || busy_a[0] !== 1'b0) begin
            fails++;
            $display("FAIL midframe_remainder errs=%0d busy=%b expected 0 0", err_cnt - e0, busy_a[0]);
        end
        test_write(0);
    endtask

    initial begin
        test_reset();
        test_write(0);
        test_read(0);
        test_burst_write();
        test_burst_read();
        test_abort();
        for (int k = 1; k <= 3; k++) begin
            test_write(k);
            test_read(k);
        end
        test_no_burst();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
